// File: rtl/axis_cp_insert.sv
// ---------------------------------------------------------------------------
// axis_cp_insert
//
// Cyclic-prefix insertion stage for the OFDM transmit chain. It sits after
// the 64-point IFFT and feeds the DAC / output framing path.
//
// Operation:
//   - Buffers one complete time-domain symbol of N samples from the AXI4-Stream
//     slave port.
//   - Replays the last CP_LEN samples as the cyclic prefix.
//   - Then replays the whole N-sample symbol on the AXI4-Stream master port,
//     with tlast on the final sample of the CP+symbol frame.
//   - There is a single buffer, so input and output phases never overlap.
//
// Parameters:
//   N       samples per OFDM symbol (power of 2, 8..256)
//   CP_LEN  cyclic prefix length in samples (1..N-1)
//   DATA_W  sample width, packed {I,Q}; data is never modified
//
// Ports:
//   aclk, aresetn       clock, synchronous active-low reset
//   s_axis_*            sample input (tdata/tvalid/tlast in, tready out)
//   m_axis_*            CP+symbol output (tdata/tvalid/tlast out, tready in)
//   en                  global enable; low freezes every register and
//                       forces both handshake outputs low
//   frame_err           sticky input framing error
//
// Optional build macro:
//   AXIS_CP_INSERT_TLAST_CHECK_EN
//     - When defined, s_axis_tlast is compared against the internal sample
//       count and frame_err latches any disagreement until reset.
//     - When undefined, s_axis_tlast is ignored and frame_err is tied to 0.
// ---------------------------------------------------------------------------
module axis_cp_insert #(
   parameter int N      = 64,
   parameter int CP_LEN = 16,
   parameter int DATA_W = 32
) (
   input  logic              aclk,
   input  logic              aresetn,
   output logic              s_axis_tready,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   input  logic              m_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              en,
   output logic              frame_err
);

   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
   localparam logic [AW-1:0] CP_LAST  = AW'(CP_LEN - 1);
   localparam logic [AW-1:0] CP_BASE  = AW'(N - CP_LEN);

   typedef enum logic [1:0] {
      S_READ,
      S_SYM,
      S_CP
   } state_t;

   state_t            state_q, state_d;
   logic [AW-1:0]     wrCnt_q, wrCnt_d;
   logic [AW-1:0]     rdCnt_q, rdCnt_d;
   logic [DATA_W-1:0] symBuf_q [N];
   logic [AW-1:0]     rdAddr;
   logic              inXfer;
   logic              outXfer;

   // A handshake only counts while enabled and in the phase that owns that
   // port. Because en is folded in here, en low automatically freezes the
   // counters, the FSM and the buffer.
   assign inXfer  = en && s_axis_tvalid && (state_q == S_READ);
   assign outXfer = en && m_axis_tready && (state_q != S_READ);

   // Output side is combinational from state and read counter.
   // - During the prefix the read pointer is offset to the tail of the
   //   symbol. The AW-bit add cannot exceed N-1, so no wrap is needed.
   // - tready/tvalid are gated by en so that a pause drops both immediately.
   always_comb begin
      s_axis_tready = en && (state_q == S_READ);
      m_axis_tvalid = en && (state_q != S_READ);
      rdAddr        = (state_q == S_CP) ? (CP_BASE + rdCnt_q) : rdCnt_q;
      m_axis_tdata  = symBuf_q[rdAddr];
      m_axis_tlast  = (state_q == S_SYM) && (rdCnt_q == LAST_IDX);
   end

   // Next-state logic for the read/prefix/symbol sequence.
   // - Each counter wraps to zero exactly at its terminal count, which is
   //   also the point where the FSM advances.
   // - Entering S_CP clears rdCnt so that the prefix always starts at the
   //   first tail sample.
   always_comb begin
      state_d = state_q;
      wrCnt_d = wrCnt_q;
      rdCnt_d = rdCnt_q;
      unique case (state_q)
         S_READ: begin
            if (inXfer) begin
               if (wrCnt_q == LAST_IDX) begin
                  wrCnt_d = '0;
                  rdCnt_d = '0;
                  state_d = S_CP;
               end else begin
                  wrCnt_d = wrCnt_q + AW'(1);
               end
            end
         end
         S_CP: begin
            if (outXfer) begin
               if (rdCnt_q == CP_LAST) begin
                  rdCnt_d = '0;
                  state_d = S_SYM;
               end else begin
                  rdCnt_d = rdCnt_q + AW'(1);
               end
            end
         end
         S_SYM: begin
            if (outXfer) begin
               if (rdCnt_q == LAST_IDX) begin
                  rdCnt_d = '0;
                  state_d = S_READ;
               end else begin
                  rdCnt_d = rdCnt_q + AW'(1);
               end
            end
         end
         default: begin
            state_d = S_READ;
            wrCnt_d = '0;
            rdCnt_d = '0;
         end
      endcase
   end

   // FSM and counter registers. A reset mid-symbol simply drops back to
   // S_READ with empty counters, so the partial symbol is never replayed.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state_q <= S_READ;
         wrCnt_q <= '0;
         rdCnt_q <= '0;
      end else begin
         state_q <= state_d;
         wrCnt_q <= wrCnt_d;
         rdCnt_q <= rdCnt_d;
      end
   end

   // Symbol storage. It is deliberately not reset: every location is
   // rewritten before it is read again, so its power-up contents never
   // reach the output.
   always_ff @(posedge aclk) begin
      if (inXfer) begin
         symBuf_q[wrCnt_q] <= s_axis_tdata;
      end
   end

`ifdef AXIS_CP_INSERT_TLAST_CHECK_EN
   logic frameErr_q, frameErr_d;

   // The input tlast must line up with the last sample slot. Any mismatch
   // latches the error flag. Framing itself always follows wrCnt, so a bad
   // tlast never disturbs the datapath.
   always_comb begin
      frameErr_d = frameErr_q;
      if (inXfer && (s_axis_tlast != (wrCnt_q == LAST_IDX))) begin
         frameErr_d = 1'b1;
      end
   end

   // Sticky error register, cleared only by reset.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         frameErr_q <= 1'b0;
      end else begin
         frameErr_q <= frameErr_d;
      end
   end

   assign frame_err = frameErr_q;
`else
   logic unusedTlast;

   assign unusedTlast = s_axis_tlast;
   assign frame_err   = 1'b0;
`endif

endmodule

// File: tb/tb_axis_cp_insert.sv
// ---------------------------------------------------------------------------
// tb_axis_cp_insert
//
// Directed bench for axis_cp_insert with N=64, CP_LEN=16, DATA_W=32.
// - A table of frame scenarios is walked in a loop: ramp, random
//   backpressure, back-to-back symbols and en pauses.
// - Hand-written sequences then cover a reset in the middle of the output
//   phase and a misplaced input tlast.
// - The expected 80-sample frame for a base value b is
//   b+48..b+63 followed by b+0..b+63, with tlast on the last sample only.
// ---------------------------------------------------------------------------
module tb_axis_cp_insert;

   localparam int N      = 64;
   localparam int CP_LEN = 16;
   localparam int DATA_W = 32;
   localparam int FRAME  = N + CP_LEN;
   localparam int BUDGET = 2000;

   logic              aclk;
   logic              aresetn;
   logic              s_axis_tready;
   logic [DATA_W-1:0] s_axis_tdata;
   logic              s_axis_tvalid;
   logic              s_axis_tlast;
   logic              m_axis_tready;
   logic [DATA_W-1:0] m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tlast;
   logic              en;
   logic              frame_err;

   int  checks;
   int  passes;
   bit  errExp;

   typedef struct {
      int base;
      bit bp;
      int pauseIn;
      int pauseOut;
      int expFirst;
      int expLast;
   } vec_t;

   vec_t vecs [5];

   axis_cp_insert #(
      .N      (N),
      .CP_LEN (CP_LEN),
      .DATA_W (DATA_W)
   ) dut (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tready (s_axis_tready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .en            (en),
      .frame_err     (frame_err)
   );

   // Free-running 10-unit clock.
   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   // One comparison: bump the counters and report any difference.
   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) begin
         passes++;
      end else begin
         $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Hold en low for a few cycles and confirm that both handshakes drop.
   task automatic enPause(input string name);
      en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge aclk);
         checkOutput({name, "_tready"}, 32'(s_axis_tready), 32'd0);
         checkOutput({name, "_tvalid"}, 32'(m_axis_tvalid), 32'd0);
         @(posedge aclk); #1;
      end
      en = 1'b1;
   endtask

   // Push one symbol and drain its CP+symbol frame.
   // - Inputs are driven 1 unit after the rising edge and outputs are
   //   sampled on the falling edge.
   // - abortAt < FRAME stops the drain early, for the reset test.
   // - errAt >= 0 places tlast on that input index instead of the last one.
   task automatic applyStimulus(input int base, input bit bp, input int pauseIn,
                                input int pauseOut, input int expFirst, input int expLast,
                                input int abortAt, input int errAt);
      logic [31:0] expq [FRAME];
      int          j;
      int          cyc;
      bit          rdy;
      bit          doPause;

      for (int k = 0; k < CP_LEN; k++) expq[k] = 32'(base + N - CP_LEN + k);
      for (int k = 0; k < N; k++)      expq[CP_LEN + k] = 32'(base + k);

      // Input phase: tready equals en in S_READ, so every cycle transfers.
      m_axis_tready = 1'b1;
      s_axis_tvalid = 1'b1;
      for (int i = 0; i < N; i++) begin
         s_axis_tdata = 32'(base + i);
         s_axis_tlast = (errAt >= 0) ? (i == errAt) : (i == N - 1);
         @(negedge aclk);
         checkOutput("in_tready", 32'(s_axis_tready), 32'd1);
         checkOutput("in_m_tvalid", 32'(m_axis_tvalid), 32'd0);
         checkOutput("in_frame_err", 32'(frame_err), 32'(errExp));
         @(posedge aclk); #1;
`ifdef AXIS_CP_INSERT_TLAST_CHECK_EN
         if (errAt >= 0 && (i == errAt || i == N - 1)) errExp = 1'b1;
`endif
         if (i == pauseIn) enPause("in_pause");
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;

      // Output phase. The first sample must be valid straight away.
      j   = 0;
      cyc = 0;
      while (j < abortAt && cyc < BUDGET) begin
         rdy           = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         m_axis_tready = rdy;
         doPause       = 1'b0;
         @(negedge aclk);
         checkOutput("out_tvalid", 32'(m_axis_tvalid), 32'd1);
         checkOutput("out_s_tready", 32'(s_axis_tready), 32'd0);
         if (m_axis_tvalid) begin
            checkOutput("out_tdata", m_axis_tdata, expq[j]);
            checkOutput("out_tlast", 32'(m_axis_tlast), 32'(j == FRAME - 1));
            if (j == 0)         checkOutput("out_first", m_axis_tdata, 32'(expFirst));
            if (j == FRAME - 1) checkOutput("out_last", m_axis_tdata, 32'(expLast));
            if (rdy) begin
               j++;
               doPause = (j == pauseOut + 1);
            end
         end
         @(posedge aclk); #1;
         cyc++;
         if (doPause) enPause("out_pause");
      end
      if (cyc >= BUDGET) checkOutput("out_timeout", 32'(j), 32'(abortAt));

      // After a full frame the slave side must reopen in the very next cycle.
      if (abortAt == FRAME) begin
         m_axis_tready = 1'b0;
         @(negedge aclk);
         checkOutput("end_s_tready", 32'(s_axis_tready), 32'd1);
         checkOutput("end_m_tvalid", 32'(m_axis_tvalid), 32'd0);
         checkOutput("end_m_tlast", 32'(m_axis_tlast), 32'd0);
         @(posedge aclk); #1;
      end
   endtask

   // Main sequence: reset checks, table walk, then the hand-written corners.
   initial begin
      checks        = 0;
      passes        = 0;
      errExp        = 1'b0;
      aresetn       = 1'b0;
      en            = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b0;

      //          base bp  pIn pOut first last
      vecs[0] = '{0,   0,  -1, -1,  48,   63};
      vecs[1] = '{0,   1,  -1, -1,  48,   63};
      vecs[2] = '{0,   0,  -1, -1,  48,   63};
      vecs[3] = '{100, 0,  -1, -1,  148,  163};
      vecs[4] = '{0,   1,  30, 20,  48,   63};

      // Reset with en low: tready follows en, so it must read 0.
      @(posedge aclk); #1;
      @(negedge aclk);
      checkOutput("rst_tready_en0", 32'(s_axis_tready), 32'd0);
      en = 1'b1;
      @(negedge aclk);
      checkOutput("rst_tready", 32'(s_axis_tready), 32'd1);
      checkOutput("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
      checkOutput("rst_tlast", 32'(m_axis_tlast), 32'd0);
      checkOutput("rst_frame_err", 32'(frame_err), 32'd0);
      @(posedge aclk); #1;
      aresetn = 1'b1;

      for (int v = 0; v < 5; v++) begin
         applyStimulus(vecs[v].base, vecs[v].bp, vecs[v].pauseIn, vecs[v].pauseOut,
                       vecs[v].expFirst, vecs[v].expLast, FRAME, -1);
      end

      // Reset after 10 output transfers, then a fresh frame must be complete.
      applyStimulus(200, 0, -1, -1, 248, 263, 10, -1);
      m_axis_tready = 1'b0;
      aresetn       = 1'b0;
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      checkOutput("midrst_tready", 32'(s_axis_tready), 32'd1);
      checkOutput("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
      @(posedge aclk); #1;
      applyStimulus(0, 0, -1, -1, 48, 63, FRAME, -1);

      // tlast on sample 40: the datapath is unchanged, and frame_err is
      // sticky when the check is built in and stays 0 otherwise.
      applyStimulus(0, 1, -1, -1, 48, 63, FRAME, 40);
      @(negedge aclk);
      checkOutput("frame_err_final", 32'(frame_err), 32'(errExp));
      @(posedge aclk); #1;

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
